text_cmd_engine: RTL and testbench
==================================

TEXT_CMD_ENGINE -- requirements
Module: text_cmd_engine

Interface
REQ-001 Parameters SHALL be: COLS, default 80, characters per row.
REQ-002 ROWS, default 30, rows per screen.
REQ-003 COL_BITS, default 8, column field width; VRAM address = {row, col[COL_BITS-1:0]}.
REQ-004 ADDR_W, default 16, VRAM address width.
REQ-005 FIFO_DEPTH, default 4 (power of two, >=2), CPU write buffer depth.
REQ-006 Ports SHALL be: clk in 1, sole clock.
REQ-007 rst in 1, synchronous, active-high reset.
REQ-008 cpu_we in 1, CPU write request; cpu_waddr in ADDR_W; cpu_wdata in 8.
REQ-009 cpu_ready out 1, high when the FIFO can accept a write.
REQ-010 cmd_valid in 1; cmd_op in 2 (0 CLEAR_ALL, 1 CLEAR_LINE, 2 SCROLL_UP, 3 FILL_ALL); cmd_line in 8; cmd_char in 8.
REQ-011 cmd_ready out 1; busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky until next accepted command).
REQ-012 vram_we out 1; vram_waddr out ADDR_W; vram_wdata out 8.
REQ-013 vram_re out 1; vram_raddr out ADDR_W; vram_rdata in 8, valid the cycle after vram_re.

Function
REQ-014 A CPU write SHALL be accepted when cpu_we && cpu_ready and pushed into the FIFO; a write with cpu_ready low SHALL be dropped.
REQ-015 cpu_ready SHALL equal !fifo_full.
REQ-016 In IDLE with the FIFO non-empty, one entry per cycle SHALL pop to vram_we/vram_waddr/vram_wdata, registered (1-cycle latency from push into an empty FIFO).
REQ-017 The FIFO SHALL not pop outside IDLE; pushes SHALL continue while the engine is busy.
REQ-018 Simultaneous push and pop on a full FIFO SHALL be rejected (cpu_ready low); on a non-full FIFO both SHALL occur and the count SHALL be unchanged.
REQ-019 cmd_ready SHALL equal (state==IDLE) && fifo_empty && !pop_in_progress; a command SHALL be accepted on cmd_valid && cmd_ready.
REQ-020 States SHALL be IDLE, FILL, SC_RD, SC_WR, DONE.
REQ-021 On accept of CLEAR_ALL, FILL_ALL, or CLEAR_LINE, the engine SHALL go to FILL, with char = 8'h20 for the clears and cmd_char for FILL_ALL.
REQ-022 FILL SHALL write one cell per cycle, col 0..COLS-1 within each row.
REQ-023 Row range SHALL be 0..ROWS-1 for ALL ops, and cmd_line only for CLEAR_LINE.
REQ-024 On accept of SCROLL_UP, the engine SHALL go to SC_RD.
REQ-025 SC_RD SHALL assert vram_re at (r,c) for r = 1..ROWS-1; SC_WR SHALL write vram_rdata to (r-1,c); the two states SHALL alternate.
REQ-026 After the last cell of row ROWS-1, the engine SHALL go to FILL for row ROWS-1 with 8'h20.
REQ-027 After the last write of any op, the engine SHALL go to DONE: done=1 for one cycle, then IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Cycle counts from accept to done SHALL be: CLEAR_ALL/FILL_ALL = ROWS*COLS+1; CLEAR_LINE = COLS+1; SCROLL_UP = 2*(ROWS-1)*COLS+COLS+1.
REQ-030 CLEAR_LINE with cmd_line>=ROWS SHALL perform no writes, set err, and go directly to DONE.
REQ-031 ROWS==1 SCROLL_UP SHALL reduce to a fill of row 0.
REQ-032 Column and row counters SHALL wrap col COLS-1 to 0 with row increment; the address SHALL be zero-extended to ADDR_W.
REQ-033 cmd_valid while not ready SHALL be ignored; no queuing.
REQ-034 vram_we and vram_re SHALL never both be driven by the FIFO and the engine in the same cycle.

Reset
REQ-035 While rst is high: state SHALL be IDLE, FIFO SHALL be emptied, counters SHALL be 0.
REQ-036 While rst is high: vram_we=0, vram_re=0, vram_waddr=0, vram_wdata=0, vram_raddr=0.
REQ-037 While rst is high: busy=0, done=0, err=0.
REQ-038 cmd_ready=1 and cpu_ready=1 SHALL hold from the first cycle after reset.
REQ-039 Reset mid-operation SHALL abort the op with no done pulse and SHALL discard FIFO contents.

Verification
REQ-040 CLEAR_LINE cmd_line=5 -> 80 writes of 8'h20 at 0x0500..0x054F; done at cycle 81; no other addresses written.
REQ-041 SCROLL_UP on a VRAM model with cell(r,c)=r -> after done, rows 0..28 hold 1..29, row 29 holds 8'h20; done at cycle 4721.
REQ-042 Issue 6 CPU writes during CLEAR_ALL -> first 4 accepted, cpu_ready low for the rest; after done the 4 writes appear in order; cmd_ready rises only when the FIFO is empty.
REQ-043 FILL_ALL cmd_char=8'h41 -> 2400 writes of 8'h41; busy high 2400 cycles; single done pulse.
REQ-044 CLEAR_LINE cmd_line=30 -> no vram_we; err=1; done next cycle.
REQ-045 Assert rst at cycle 100 of SCROLL_UP -> next cycle busy=0, vram_we=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/text_cmd_engine.sv
// Text-mode VRAM command engine: buffers CPU cell writes and runs bulk clear/fill/scroll ops.
// Latency: a CPU write reaches vram_we one cycle after push into an empty FIFO; ops take a fixed cycle count from accept to done.
// Backpressure: cpu_ready drops when the write FIFO is full; cmd_ready is high only when idle, the FIFO is empty and no pop is in flight.
// Ports: clk/rst (sync, active-high); cpu_we/cpu_waddr/cpu_wdata/cpu_ready write path;
//        cmd_valid/cmd_op/cmd_line/cmd_char/cmd_ready command path; busy/done/err status;
//        vram_we/vram_waddr/vram_wdata write port, vram_re/vram_raddr/vram_rdata read port (rdata one cycle after re).
module text_cmd_engine #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int COL_BITS   = 8,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_line,
    input  logic [7:0]        cmd_char,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [7:0]        vram_wdata,
    output logic              vram_re,
    output logic [ADDR_W-1:0] vram_raddr,
    input  logic [7:0]        vram_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
    localparam logic [8:0] ROWS_9 = 9'(ROWS);
    localparam logic [1:0] OP_CLEAR_ALL  = 2'd0;
    localparam logic [1:0] OP_CLEAR_LINE = 2'd1;
    localparam logic [1:0] OP_FILL_ALL   = 2'd3;

    typedef enum logic [2:0] {IDLE, FILL, SC_RD, SC_WR, DONE} state_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] r, input logic [COL_BITS-1:0] c);
        return ADDR_W'({r, c});
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           row_q, row_d, end_row_q, end_row_d;
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [7:0]           char_q, char_d;
    logic                 err_q, err_d;
    logic                 col_last;

    logic                 eng_we, eng_re;
    logic [ADDR_W-1:0]    eng_waddr, eng_raddr;
    logic [7:0]           eng_wdata;

    // Write buffer: entries are {addr, data}
    logic [ADDR_W+7:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 fifo_full, fifo_empty;
    logic                 push, push_store, pop, bypass, cmd_acc;
    logic                 pop_vld_q;
    logic [ADDR_W-1:0]    pop_addr_q;
    logic [7:0]           pop_data_q;

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign cpu_ready  = !fifo_full;
    assign cmd_ready  = (state_q == IDLE) && fifo_empty && !pop_vld_q;
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign push       = cpu_we && cpu_ready;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    // An idle engine with an empty buffer forwards the incoming write straight to the
    // output register, unless a command is starting this cycle and will own the port.
    assign bypass     = (state_q == IDLE) && fifo_empty && push && !cmd_acc;
    assign push_store = push && !bypass;
    assign col_last   = (col_q == COL_BITS'(COLS - 1));

    always_ff @(posedge clk) begin
        if (push_store) mem[wr_ptr] <= {cpu_waddr, cpu_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pop_vld_q  <= 1'b0;
            pop_addr_q <= '0;
            pop_data_q <= '0;
        end else begin
            if (push_store) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_store, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
            pop_vld_q <= pop || bypass;
            if (pop) begin
                pop_addr_q <= mem[rd_ptr][ADDR_W+7:8];
                pop_data_q <= mem[rd_ptr][7:0];
            end else if (bypass) begin
                pop_addr_q <= cpu_waddr;
                pop_data_q <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            end_row_q <= '0;
            char_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            end_row_q <= end_row_d;
            char_q    <= char_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        end_row_d = end_row_q;
        char_d    = char_q;
        err_d     = err_q;
        eng_we    = 1'b0;
        eng_re    = 1'b0;
        eng_waddr = '0;
        eng_raddr = '0;
        eng_wdata = '0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    err_d     = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    end_row_d = ROW_LAST;
                    char_d    = 8'h20;
                    case (cmd_op)
                        OP_CLEAR_ALL: state_d = FILL;
                        OP_FILL_ALL: begin
                            state_d = FILL;
                            char_d  = cmd_char;
                        end
                        OP_CLEAR_LINE: begin
                            if ({1'b0, cmd_line} < ROWS_9) begin
                                row_d     = cmd_line;
                                end_row_d = cmd_line;
                                state_d   = FILL;
                            end else begin
                                err_d   = 1'b1;
                                state_d = DONE;
                            end
                        end
                        default: begin
                            // With a single row there is nothing to move; only the blank fill remains.
                            if (ROWS == 1) begin
                                state_d = FILL;
                            end else begin
                                row_d   = 8'd1;
                                state_d = SC_RD;
                            end
                        end
                    endcase
                end
            end
            FILL: begin
                eng_we    = 1'b1;
                eng_waddr = cell_addr(row_q, col_q);
                eng_wdata = char_q;
                if (col_last) begin
                    col_d = '0;
                    if (row_q == end_row_q) state_d = DONE;
                    else                    row_d   = row_q + 8'd1;
                end else begin
                    col_d = col_q + COL_BITS'(1);
                end
            end
            SC_RD: begin
                eng_re    = 1'b1;
                eng_raddr = cell_addr(row_q, col_q);
                state_d   = SC_WR;
            end
            SC_WR: begin
                // vram_rdata now holds cell (row, col) read in the previous cycle.
                eng_we    = 1'b1;
                eng_waddr = cell_addr(row_q - 8'd1, col_q);
                eng_wdata = vram_rdata;
                state_d   = SC_RD;
                if (col_last) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = FILL;
                        char_d  = 8'h20;
                    end else begin
                        row_d = row_q + 8'd1;
                    end
                end else begin
                    col_d = col_q + COL_BITS'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO pops only land while idle and no command can start then, so the two
    // write sources never overlap.
    assign vram_we    = !rst && (pop_vld_q || eng_we);
    assign vram_waddr = rst ? '0 : (pop_vld_q ? pop_addr_q : eng_waddr);
    assign vram_wdata = rst ? '0 : (pop_vld_q ? pop_data_q : eng_wdata);
    assign vram_re    = !rst && eng_re;
    assign vram_raddr = rst ? '0 : eng_raddr;
    assign busy       = !rst && (state_q != IDLE);
    assign done       = !rst && (state_q == DONE);
    assign err        = !rst && err_q;
endmodule

// File: tb/tb_text_cmd_engine.sv
module tb_text_cmd_engine;
    localparam int COLS = 80, ROWS = 30, COL_BITS = 8, ADDR_W = 16, FIFO_DEPTH = 4;

    logic              clk = 1'b0, rst = 1'b1;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_waddr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic              cpu_ready;
    logic              cmd_valid = 1'b0;
    logic [1:0]        cmd_op = '0;
    logic [7:0]        cmd_line = '0, cmd_char = '0;
    logic              cmd_ready, busy, done, err;
    logic              vram_we, vram_re;
    logic [ADDR_W-1:0] vram_waddr, vram_raddr;
    logic [7:0]        vram_wdata;
    logic [7:0]        vram_rdata = '0;

    text_cmd_engine #(.COLS(COLS), .ROWS(ROWS), .COL_BITS(COL_BITS), .ADDR_W(ADDR_W),
                      .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_line(cmd_line), .cmd_char(cmd_char),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
        .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .vram_re(vram_re), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wr_cnt = 0, bad_cnt = 0, done_cnt = 0, busy_nd_cnt = 0, both_cnt = 0;
    logic [ADDR_W-1:0] lo = '0, hi = '1;
    int init_seq = 0, init_pat = 0, seen_seq = 0;
    logic [7:0] vram [0:65535];

    // VRAM model: pattern 0 fills 8'hEE, pattern 1 stores the row number in each cell
    always @(posedge clk) begin
        if (init_seq != seen_seq) begin
            seen_seq = init_seq;
            for (int a = 0; a < 8192; a++)
                vram[a] <= (init_pat == 0) ? 8'hEE : 8'(a >> 8);
        end else begin
            if (vram_we) vram[vram_waddr] <= vram_wdata;
        end
        if (vram_re) vram_rdata <= vram[vram_raddr];
    end

    always @(negedge clk) begin
        if (vram_we) begin
            wr_cnt++;
            if (vram_waddr < lo || vram_waddr > hi) bad_cnt++;
        end
        if (vram_we && vram_re) both_cnt++;
        if (done) done_cnt++;
        if (busy && !done) busy_nd_cnt++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic init_vram(input int pat);
        init_pat = pat;
        init_seq++;
        step();
    endtask

    // Drives one command; n = cycle (1 = cycle after accept) in which done is seen, -1 on timeout
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] line, input logic [7:0] ch, output int n);
        cmd_op = op; cmd_line = line; cmd_char = ch; cmd_valid = 1'b1;
        n = -1;
        for (int i = 1; i <= 6000; i++) begin
            step();
            cmd_valid = 1'b0;
            if (done) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (vram_we !== 1'b0)  begin errors++; $display("FAIL rst_vram_we got %b want 0", vram_we); end
        checks++; if (vram_re !== 1'b0)  begin errors++; $display("FAIL rst_vram_re got %b want 0", vram_re); end
        checks++; if (vram_waddr !== '0) begin errors++; $display("FAIL rst_waddr got %h want 0", vram_waddr); end
        checks++; if (vram_wdata !== '0) begin errors++; $display("FAIL rst_wdata got %h want 0", vram_wdata); end
        checks++; if (vram_raddr !== '0) begin errors++; $display("FAIL rst_raddr got %h want 0", vram_raddr); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_status got %b want 000", {busy, done, err}); end
        rst = 1'b0;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_cpu_ready got %b want 1", cpu_ready); end
    endtask

    task automatic test_cpu_write();
        cpu_we = 1'b1; cpu_waddr = 16'h0123; cpu_wdata = 8'h5A;
        step();
        cpu_we = 1'b1; cpu_waddr = 16'h0124; cpu_wdata = 8'h5B;
        checks++; if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 16'h0123, 8'h5A})
            begin errors++; $display("FAIL cpu_wr0 got %b %h %h want 1 0123 5a", vram_we, vram_waddr, vram_wdata); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cpu_pop_cmd_ready got %b want 0", cmd_ready); end
        step();
        cpu_we = 1'b0;
        checks++; if ({vram_we, vram_waddr, vram_wdata} !== {1'b1, 16'h0124, 8'h5B})
            begin errors++; $display("FAIL cpu_wr1 got %b %h %h want 1 0124 5b", vram_we, vram_waddr, vram_wdata); end
        step();
        checks++; if ({vram_we, cmd_ready} !== 2'b01) begin errors++; $display("FAIL cpu_after got we=%b rdy=%b want 0 1", vram_we, cmd_ready); end
    endtask

    task automatic test_clear_line();
        int n, w0, b0, mism;
        init_vram(0);
        lo = 16'h0500; hi = 16'h054F;
        w0 = wr_cnt; b0 = bad_cnt;
        do_cmd(2'd1, 8'd5, 8'h00, n);
        checks++; if (n !== 81) begin errors++; $display("FAIL cl_done_cycle got %0d want 81", n); end
        repeat (3) step();
        checks++; if (wr_cnt - w0 !== 80) begin errors++; $display("FAIL cl_writes got %0d want 80", wr_cnt - w0); end
        checks++; if (bad_cnt - b0 !== 0) begin errors++; $display("FAIL cl_stray got %0d want 0", bad_cnt - b0); end
        mism = 0;
        for (int c = 0; c < COLS; c++) if (vram[16'h0500 + c] !== 8'h20) mism++;
        checks++; if (mism !== 0) begin errors++; $display("FAIL cl_cells got %0d bad want 0", mism); end
        checks++; if ({vram[16'h04FF], vram[16'h0550], vram[16'h0600]} !== 24'hEEEEEE)
            begin errors++; $display("FAIL cl_neighbours got %h %h %h want ee", vram[16'h04FF], vram[16'h0550], vram[16'h0600]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL cl_err got %b want 0", err); end
    endtask

    task automatic test_bad_line();
        int n, w0;
        lo = 16'hFFFF; hi = 16'h0000;
        w0 = wr_cnt;
        do_cmd(2'd1, 8'd30, 8'h00, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL bl_done_cycle got %0d want 1", n); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bl_err got %b want 1", err); end
        repeat (3) step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bl_err_sticky got %b want 1", err); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL bl_writes got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_fill_all();
        int n, w0, bz0, d0;
        lo = 16'h0000; hi = 16'h1D4F;
        w0 = wr_cnt; bz0 = busy_nd_cnt; d0 = done_cnt;
        cmd_op = 2'd3; cmd_char = 8'h41; cmd_valid = 1'b1;
        n = -1;
        for (int i = 1; i <= 6000; i++) begin
            step();
            cmd_op = 2'd1; cmd_line = 8'd2;
            cmd_valid = (i >= 10 && i < 13);  // must be ignored while busy
            if (i == 1) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL fa_err_clear got %b want 0", err); end
            end
            if (done) begin n = i; break; end
        end
        cmd_valid = 1'b0;
        repeat (5) step();
        checks++; if (n !== 2401) begin errors++; $display("FAIL fa_done_cycle got %0d want 2401", n); end
        checks++; if (wr_cnt - w0 !== 2400) begin errors++; $display("FAIL fa_writes got %0d want 2400", wr_cnt - w0); end
        checks++; if (busy_nd_cnt - bz0 !== 2400) begin errors++; $display("FAIL fa_busy got %0d want 2400", busy_nd_cnt - bz0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL fa_done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if ({vram[16'h0000], vram[16'h1D4F], vram[16'h0050]} !== {8'h41, 8'h41, 8'hEE})
            begin errors++; $display("FAIL fa_cells got %h %h %h want 41 41 ee", vram[16'h0000], vram[16'h1D4F], vram[16'h0050]); end
    endtask

    task automatic test_scroll();
        int n, w0, b0, mism;
        logic [7:0] exp;
        init_vram(1);
        lo = 16'h0000; hi = 16'h1D4F;
        w0 = wr_cnt; b0 = bad_cnt;
        do_cmd(2'd2, 8'd0, 8'h00, n);
        checks++; if (n !== 4721) begin errors++; $display("FAIL sc_done_cycle got %0d want 4721", n); end
        repeat (3) step();
        mism = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                exp = (r < ROWS - 1) ? 8'(r + 1) : 8'h20;
                if (vram[(r << 8) + c] !== exp) mism++;
            end
        checks++; if (mism !== 0) begin errors++; $display("FAIL sc_cells got %0d bad want 0", mism); end
        checks++; if ({vram[16'h0000], vram[16'h1C4F], vram[16'h1D00]} !== {8'd1, 8'd29, 8'h20})
            begin errors++; $display("FAIL sc_spot got %h %h %h want 01 1d 20", vram[16'h0000], vram[16'h1C4F], vram[16'h1D00]); end
        checks++; if (wr_cnt - w0 !== 2400) begin errors++; $display("FAIL sc_writes got %0d want 2400", wr_cnt - w0); end
        checks++; if (bad_cnt - b0 !== 0) begin errors++; $display("FAIL sc_stray got %0d want 0", bad_cnt - b0); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL we_re_overlap got %0d want 0", both_cnt); end
    endtask

    task automatic test_back_to_back();
        int n, k;
        cmd_op = 2'd0; cmd_valid = 1'b1;
        n = -1;
        for (int i = 1; i <= 6000; i++) begin
            step();
            cmd_valid = 1'b0;
            cpu_we = 1'b0;
            if (i >= 5 && i <= 10) begin
                k = i - 5;
                checks++; if (cpu_ready !== (k < 4))
                    begin errors++; $display("FAIL bb_cpu_ready%0d got %b want %b", k, cpu_ready, (k < 4)); end
                cpu_we = 1'b1; cpu_waddr = 16'h0A00 + 16'(k); cpu_wdata = 8'h60 + 8'(k);
            end
            if (done) begin n = i; break; end
        end
        cpu_we = 1'b0;
        checks++; if (n !== 2401) begin errors++; $display("FAIL bb_done_cycle got %0d want 2401", n); end
        step();
        checks++; if ({vram_we, cmd_ready} !== 2'b00) begin errors++; $display("FAIL bb_idle got we=%b rdy=%b want 0 0", vram_we, cmd_ready); end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++; if ({vram_we, vram_waddr, vram_wdata, cmd_ready} !== {1'b1, 16'h0A00 + 16'(j), 8'h60 + 8'(j), 1'b0})
                begin errors++; $display("FAIL bb_pop%0d got %b %h %h rdy=%b", j, vram_we, vram_waddr, vram_wdata, cmd_ready); end
        end
        step();
        checks++; if ({vram_we, cmd_ready} !== 2'b01) begin errors++; $display("FAIL bb_ready got we=%b rdy=%b want 0 1", vram_we, cmd_ready); end
        checks++; if ({vram[16'h0A03], vram[16'h0A04]} !== {8'h63, 8'h20})
            begin errors++; $display("FAIL bb_cells got %h %h want 63 20", vram[16'h0A03], vram[16'h0A04]); end
    endtask

    task automatic test_reset_mid_scroll();
        int d0, w0;
        d0 = done_cnt;
        cmd_op = 2'd2; cmd_valid = 1'b1;
        for (int i = 1; i <= 99; i++) begin
            step();
            cmd_valid = 1'b0;
            cpu_we = (i == 50); cpu_waddr = 16'h0777; cpu_wdata = 8'h99;
        end
        rst = 1'b1;
        step();
        checks++; if ({busy, vram_we, vram_re, cmd_ready, done} !== 5'b00010)
            begin errors++; $display("FAIL mid_rst got busy=%b we=%b re=%b rdy=%b done=%b", busy, vram_we, vram_re, cmd_ready, done); end
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (20) step();
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mid_fifo_flush got %0d writes want 0", wr_cnt - w0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_done got %0d pulses want 0", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_clear_line();
        test_bad_line();
        test_fill_all();
        test_scroll();
        test_back_to_back();
        test_reset_mid_scroll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
